// File: rtl/blinker_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encodings, LFSR defaults and step function.
// Pure declarations, no logic of its own.
package blinker_pkg;

  localparam logic MODE_FIXED  = 1'b0;
  localparam logic MODE_RANDOM = 1'b1;

  localparam int              DEF_LFSR_W    = 16;
  localparam logic [15:0]     DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0]     DEF_LFSR_SEED = 16'hACE1;

  // Widest LFSR the step helper handles; callers zero-extend and truncate.
  localparam int LFSR_MAX_W = 32;

  typedef enum logic {
    CH_ARM,
    CH_RUN
  } ch_state_e;

  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/multi_blinker_if.sv
// Control/status bundle between the board-level controller and the blinker.
// Level signals only; no handshake, the blinker samples every cycle.
interface multi_blinker_if #(
  parameter int N_CH   = 3,
  parameter int CNT_W  = 8,
  parameter int LFSR_W = 16
);
  logic                    en;
  logic                    restart;
  logic [N_CH-1:0]         mode;
  logic [N_CH*CNT_W-1:0]   interval;
  logic [N_CH-1:0]         led;
  logic [LFSR_W-1:0]       lfsr_q;

  modport master (
    output en, restart, mode, interval,
    input  led, lfsr_q
  );

  modport slave (
    input  en, restart, mode, interval,
    output led, lfsr_q
  );
endinterface

// File: rtl/blinker_channel.sv
// One blinker channel: ARM/RUN period counter plus pulse stretcher; led registered, high from the blink edge.
// Latency: first blink 1+tgt cycles after entering ARM; backpressure: none, en=0 freezes state.
module blinker_channel
  import blinker_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] sample,
  output logic             led
);

  localparam int ST_W = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tgt;
  logic [ST_W-1:0]  stretch;
  logic [ST_W-1:0]  stretch_nxt;
  ch_state_e        st;
  logic             blink;

  // A zero target is the ARM state; no separate state register is needed.
  assign st    = (tgt == '0) ? CH_ARM : CH_RUN;
  assign blink = (st == CH_RUN) && (cnt == tgt - 1'b1);

  always_comb begin
    stretch_nxt = stretch;
    if (blink) begin
      stretch_nxt = ST_W'(PULSE_LEN);
    end else if (stretch != '0) begin
      stretch_nxt = stretch - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tgt     <= '0;
      stretch <= '0;
      led     <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      tgt     <= '0;
      stretch <= '0;
      led     <= 1'b0;
    end else if (!en) begin
      led <= 1'b0;
    end else begin
      case (st)
        CH_ARM: begin
          tgt <= sample;
          cnt <= '0;
        end
        CH_RUN: begin
          if (blink) begin
            cnt <= '0;
            tgt <= sample;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
          tgt <= '0;
        end
      endcase
      stretch <= stretch_nxt;
      led     <= (stretch_nxt != '0);
    end
  end

endmodule

// File: rtl/multi_blinker.sv
// N-channel LED blinker with fixed or LFSR-driven random intervals and stretchable pulses.
// Latency: led registered, blink visible the cycle after its edge; backpressure: none.
module multi_blinker
  import blinker_pkg::*;
#(
  parameter int                N_CH      = 3,
  parameter int                CNT_W     = 8,
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
  parameter int                RAND_MIN  = 4,
  parameter int                PULSE_LEN = 1
) (
  input  logic           clk,
  input  logic           rstbtn_n,
  multi_blinker_if.slave bus
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  logic [LFSR_W-1:0] lfsr;
  logic [N_CH-1:0]   led_w;

  always_ff @(posedge clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      lfsr <= SEED_EFF;
    end else if (lfsr == '0) begin
      lfsr <= SEED_EFF;
    end else if (bus.en) begin
      lfsr <= LFSR_W'(lfsr_step(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(LFSR_TAPS)));
    end
  end

  assign bus.lfsr_q = lfsr;
  assign bus.led    = led_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int ROT = i % LFSR_W;

    logic [CNT_W-1:0] rnd;
    logic [CNT_W-1:0] rnd_clamped;
    logic [CNT_W-1:0] sample;

    // Each channel sees the shared LFSR rotated by its index so channels decorrelate.
    assign rnd         = CNT_W'((lfsr << ROT) | (lfsr >> (LFSR_W - ROT)));
    assign rnd_clamped = (rnd < CNT_W'(RAND_MIN)) ? CNT_W'(RAND_MIN) : rnd;
    assign sample      = (bus.mode[i] == MODE_FIXED) ? bus.interval[i*CNT_W +: CNT_W]
                                                     : rnd_clamped;

    blinker_channel #(
      .CNT_W     (CNT_W),
      .PULSE_LEN (PULSE_LEN)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rstbtn_n),
      .en      (bus.en),
      .restart (bus.restart),
      .sample  (sample),
      .led     (led_w[i])
    );
  end

endmodule

// File: tb/tb_multi_blinker.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_multi_blinker;

  logic clk = 1'b0;
  logic rstbtn_n;

  always #5 clk = ~clk;

  multi_blinker_if #(.N_CH(3), .CNT_W(8), .LFSR_W(16)) bus_a ();
  multi_blinker_if #(.N_CH(1), .CNT_W(8), .LFSR_W(16)) bus_b ();

  multi_blinker #(.N_CH(3), .PULSE_LEN(1)) dut_a (
    .clk      (clk),
    .rstbtn_n (rstbtn_n),
    .bus      (bus_a)
  );

  multi_blinker #(.N_CH(1), .PULSE_LEN(3)) dut_b (
    .clk      (clk),
    .rstbtn_n (rstbtn_n),
    .bus      (bus_b)
  );

  typedef struct {
    int         ph;
    logic [2:0] led_a;
    logic [15:0] lfsr_a;
    logic       led_b;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          phase   = 0;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Random interval for channel 2: low byte of the state rotated left by 2, at least 4.
  function automatic int samp2(input logic [15:0] l);
    logic [7:0] r;
    r = {l[5:0], l[15:14]};
    return (r < 8'd4) ? 4 : int'(r);
  endfunction

  function automatic logic hit(input int k, input int arm, input int per);
    return (k > arm) && (((k - arm) % per) == 0);
  endfunction

  // Inputs for the coming edge are already driven; record the expected result of that edge.
  task automatic step(input logic [2:0] ea, input logic eb);
    exp_t e;
    if (rstbtn_n && bus_a.en) lfsr_m = lfsr_next(lfsr_m);
    e.ph     = phase;
    e.led_a  = ea;
    e.lfsr_a = lfsr_m;
    e.led_b  = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (bus_a.led !== e.led_a) begin
          n_fail++;
          $display("FAIL ph%0d_led_a t=%0t got %b want %b", e.ph, $time, bus_a.led, e.led_a);
        end
        n_tests++;
        if (bus_a.lfsr_q !== e.lfsr_a) begin
          n_fail++;
          $display("FAIL ph%0d_lfsr t=%0t got %h want %h", e.ph, $time, bus_a.lfsr_q, e.lfsr_a);
        end
        n_tests++;
        if (bus_b.led[0] !== e.led_b) begin
          n_fail++;
          $display("FAIL ph%0d_led_b t=%0t got %b want %b", e.ph, $time, bus_b.led[0], e.led_b);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    exp_t        e;
    int          next2;
    logic [15:0] pre;
    logic        b2;

    rstbtn_n       = 1'b0;
    bus_a.en       = 1'b0;
    bus_a.restart  = 1'b0;
    bus_a.mode     = 3'b000;
    bus_a.interval = {8'd0, 8'd5, 8'd10};
    bus_b.en       = 1'b0;
    bus_b.restart  = 1'b0;
    bus_b.mode     = 1'b0;
    bus_b.interval = 8'd5;
    lfsr_m         = 16'hACE1;
    next2          = -1;

    // Reset held with clock running.
    phase = 0;
    for (int k = 0; k < 4; k++) step(3'b000, 1'b0);

    // Fixed intervals 10/5/0; ARM on edge 1.
    rstbtn_n = 1'b1;
    bus_a.en = 1'b1;
    phase    = 1;
    for (int k = 1; k <= 43; k++) step({1'b0, hit(k, 1, 5), hit(k, 1, 10)}, 1'b0);

    // Freeze for 7 edges mid-period; blinks shift by exactly 7.
    phase    = 2;
    bus_a.en = 1'b0;
    for (int k = 44; k <= 50; k++) step(3'b000, 1'b0);
    bus_a.en = 1'b1;
    for (int k = 51; k <= 67; k++) step({1'b0, hit(k, 8, 5), hit(k, 8, 10)}, 1'b0);

    // Restart on the edge where ch0 and ch1 would both blink; ch2 then gets interval 1.
    phase         = 3;
    bus_a.restart = 1'b1;
    step(3'b000, 1'b0);
    bus_a.restart  = 1'b0;
    bus_a.interval = {8'd1, 8'd5, 8'd10};
    for (int k = 69; k <= 90; k++) step({hit(k, 69, 1), hit(k, 69, 5), hit(k, 69, 10)}, 1'b0);

    // Random interval on ch2, fixed on ch0/ch1, all re-armed on edge 92.
    phase         = 4;
    bus_a.mode    = 3'b100;
    bus_a.restart = 1'b1;
    step(3'b000, 1'b0);
    bus_a.restart = 1'b0;
    for (int k = 92; k <= 250; k++) begin
      pre = lfsr_m;
      b2  = (k == next2);
      if (k == 92 || b2) next2 = k + samp2(pre);
      step({b2, hit(k, 92, 5), hit(k, 92, 10)}, 1'b0);
    end

    // Stretched pulses on dut_b (PULSE_LEN=3) while dut_a is frozen.
    phase    = 5;
    bus_a.en = 1'b0;
    bus_b.en = 1'b1;
    for (int j = 1; j <= 20; j++) step(3'b000, (j >= 6) && (((j - 6) % 5) < 3));
    bus_b.interval = 8'd2;
    for (int j = 21; j <= 35; j++) step(3'b000, 1'b1);

    // Async reset between edges while the stretched led is high.
    phase    = 6;
    lfsr_m   = 16'hACE1;
    e.ph     = phase;
    e.led_a  = 3'b000;
    e.lfsr_a = 16'hACE1;
    e.led_b  = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #2;
    rstbtn_n = 1'b0;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    rstbtn_n = 1'b1;
    for (int j = 1; j <= 12; j++) step(3'b000, j >= 3);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
